lc3_regfile_sb: RTL and testbench

- Parametrised successor to the LC-3 8x16 register file, for the pipelined core.
- Adds a configurable number of read ports, two write-back ports with fixed priority, and an issue-side scoreboard (busy bit per register).
- Adds a sequenced bulk-clear FSM, so software or debug can zero the file without asserting reset.
- Sits between decode/issue (reads, reservations) and write-back (two result buses); also feeds the board display mux.

---
 rtl/lc3_regfile_sb.sv | 102 ++++++++++
 tb/tb_lc3_regfile_sb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_regfile_sb.sv
// rtl/lc3_regfile_sb.sv - LC-3 multi-port register file with issue scoreboard and bulk-clear sequencer.
// Optional macro LC3_RF_BYPASS_EN enables write-port to read-port forwarding.
module lc3_regfile_sb #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int NRD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    output logic [NRD-1:0]    rd_busy,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    output logic [NREG-1:0]   busy,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic [AW-1:0]     dis_sel,
    output logic [DW-1:0]     dis_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   mem [NREG];
    logic [AW-1:0]   cnt;
    logic [NREG-1:0] busy_nxt;
    logic            idle;

    assign idle     = (state == IDLE);
    assign clr_busy = (state == CLEAR);
    assign dis_data = mem[dis_sel];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (cnt == AW'(NREG - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reserve is applied last so a newly issued producer keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (idle) begin
            if (clr_req) busy_nxt = '0;
            if (we0)     busy_nxt[wa0] = 1'b0;
            if (we1)     busy_nxt[wa1] = 1'b0;
            if (rsv_en)  busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= '0;
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            if (idle) begin
                if (clr_req) cnt <= '0;
                // Port 0 is written last so it wins a same-address collision.
                if (we1) mem[wa1] <= wd1;
                if (we0) mem[wa0] <= wd0;
            end else begin
                mem[cnt] <= '0;
                cnt      <= cnt + AW'(1);
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] rak;
        assign rak = ra[k*AW +: AW];
`ifdef LC3_RF_BYPASS_EN
        logic hit0;
        logic hit1;
        assign hit0 = idle && we0 && (wa0 == rak);
        assign hit1 = idle && we1 && (wa1 == rak);
        assign rd[k*DW +: DW] = hit0 ? wd0 : (hit1 ? wd1 : mem[rak]);
        assign rd_busy[k]     = idle && busy[rak] && !hit0 && !hit1;
`else
        assign rd[k*DW +: DW] = mem[rak];
        assign rd_busy[k]     = idle && busy[rak];
`endif
    end

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// tb/tb_lc3_regfile_sb.sv - scoreboard-driven self-checking bench for lc3_regfile_sb.
module tb_lc3_regfile_sb;

`ifdef LC3_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we0, we1, rsv_en, clr_req;
    logic [2:0]  wa0, wa1, rsv_addr, dis_sel;
    logic [15:0] wd0, wd1;
    logic [5:0]  ra;
    logic [31:0] rd;
    logic [1:0]  rd_busy;
    logic [7:0]  busy;
    logic        clr_busy;
    logic [15:0] dis_data;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_q [$];
    logic [15:0] model [8];
    logic [15:0] got;
    logic [15:0] want;

    wire [15:0] rd0 = rd[15:0];
    wire [15:0] rd1 = rd[31:16];

    lc3_regfile_sb dut (
        .clk(clk), .rst(rst),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd), .rd_busy(rd_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy),
        .clr_req(clr_req), .clr_busy(clr_busy),
        .dis_sel(dis_sel), .dis_data(dis_data)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        we0 = 0; wa0 = 0; wd0 = 0;
        we1 = 0; wa1 = 0; wd1 = 0;
        rsv_en = 0; rsv_addr = 0; clr_req = 0;
        ra = 0; dis_sel = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        #2;
        vectors++; if (busy !== 8'h00) begin miscompares++; $display("FAIL reset_busy got %h want 00", busy); end
        vectors++; if (clr_busy !== 1'b0) begin miscompares++; $display("FAIL reset_clr_busy got %b want 0", clr_busy); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_rd got %h want 0", rd); end
        vectors++; if (rd_busy !== 2'b00) begin miscompares++; $display("FAIL reset_rd_busy got %b want 00", rd_busy); end
        vectors++; if (dis_data !== 16'h0) begin miscompares++; $display("FAIL reset_dis got %h want 0", dis_data); end
        #5 rst = 1;
        tick();
    endtask

    task automatic test_write_read();
        we0 = 1; wa0 = 3; wd0 = 16'h1234; ra = {3'd0, 3'd3};
        exp_q.push_back(BYP ? 16'h1234 : 16'h0000);
        #3;
        got = exp_q.pop_front();
        vectors++; if (rd0 !== got) begin miscompares++; $display("FAIL wr_same_cycle got %h want %h", rd0, got); end
        tick();
        idle_inputs(); ra = {3'd0, 3'd3}; dis_sel = 3; rsv_en = 1; rsv_addr = 1;
        exp_q.push_back(16'h1234);
        #3;
        got = exp_q.pop_front();
        vectors++; if (rd0 !== got) begin miscompares++; $display("FAIL wr_next_cycle got %h want %h", rd0, got); end
        tick();
        rsv_en = 0;
        vectors++; if (busy !== 8'h02) begin miscompares++; $display("FAIL pre_rst_busy got %h want 02", busy); end
        rst = 0;
        #2;
        vectors++; if (rd0 !== 16'h0) begin miscompares++; $display("FAIL async_rst_rd got %h want 0", rd0); end
        vectors++; if (busy !== 8'h00) begin miscompares++; $display("FAIL async_rst_busy got %h want 00", busy); end
        vectors++; if (dis_data !== 16'h0) begin miscompares++; $display("FAIL async_rst_dis got %h want 0", dis_data); end
        rst = 1;
        tick();
    endtask

    task automatic test_priority();
        idle_inputs();
        we0 = 1; wa0 = 5; wd0 = 16'hAAAA; we1 = 1; wa1 = 5; wd1 = 16'h5555; ra = {3'd5, 3'd0};
        exp_q.push_back(BYP ? 16'hAAAA : 16'h0000);
        #3;
        got = exp_q.pop_front();
        vectors++; if (rd1 !== got) begin miscompares++; $display("FAIL prio_bypass got %h want %h", rd1, got); end
        tick();
        idle_inputs(); dis_sel = 5; ra = {3'd5, 3'd0};
        exp_q.push_back(16'hAAAA);
        #3;
        got = exp_q.pop_front();
        vectors++; if (dis_data !== got) begin miscompares++; $display("FAIL prio_stored got %h want %h", dis_data, got); end
        tick();
        we0 = 1; wa0 = 0; wd0 = 16'h0101; we1 = 1; wa1 = 1; wd1 = 16'h0202;
        tick();
        idle_inputs(); ra = {3'd1, 3'd0};
        #3;
        vectors++; if (rd !== 32'h0202_0101) begin miscompares++; $display("FAIL dual_write got %h want 02020101", rd); end
        tick();
    endtask

    task automatic test_scoreboard();
        idle_inputs(); rsv_en = 1; rsv_addr = 2;
        tick();
        idle_inputs(); ra = {3'd0, 3'd2};
        #3;
        vectors++; if (busy !== 8'b0000_0100) begin miscompares++; $display("FAIL sb_busy got %b want 00000100", busy); end
        vectors++; if (rd_busy[0] !== 1'b1) begin miscompares++; $display("FAIL sb_rd_busy got %b want 1", rd_busy[0]); end
        tick();
        we1 = 1; wa1 = 2; wd1 = 16'h0F0F;
        exp_q.push_back(BYP ? 16'h0F0F : 16'h0000);
        #3;
        got = exp_q.pop_front();
        vectors++; if (rd_busy[0] !== !BYP) begin miscompares++; $display("FAIL sb_wb_rd_busy got %b want %b", rd_busy[0], !BYP); end
        vectors++; if (rd0 !== got) begin miscompares++; $display("FAIL sb_wb_rd got %h want %h", rd0, got); end
        tick();
        we1 = 0;
        #3;
        vectors++; if (busy[2] !== 1'b0) begin miscompares++; $display("FAIL sb_release got %b want 0", busy[2]); end
        vectors++; if (rd0 !== 16'h0F0F) begin miscompares++; $display("FAIL sb_committed got %h want 0f0f", rd0); end
        tick();
    endtask

    task automatic test_rsv_wb();
        idle_inputs(); rsv_en = 1; rsv_addr = 4; we0 = 1; wa0 = 4; wd0 = 16'h4444;
        tick();
        idle_inputs(); dis_sel = 4; ra = {3'd0, 3'd4};
        #3;
        vectors++; if (busy[4] !== 1'b1) begin miscompares++; $display("FAIL rsvwb_busy got %b want 1", busy[4]); end
        vectors++; if (dis_data !== 16'h4444) begin miscompares++; $display("FAIL rsvwb_data got %h want 4444", dis_data); end
        vectors++; if (rd_busy[0] !== 1'b1) begin miscompares++; $display("FAIL rsvwb_rd_busy got %b want 1", rd_busy[0]); end
        tick();
    endtask

    task automatic test_clear();
        int n_busy;
        for (int i = 0; i < 8; i += 2) begin
            idle_inputs();
            model[i]     = 16'(16'h1111 * (i + 1));
            model[i + 1] = 16'(16'h1111 * (i + 2));
            we0 = 1; wa0 = 3'(i);     wd0 = model[i];
            we1 = 1; wa1 = 3'(i + 1); wd1 = model[i + 1];
            tick();
        end
        idle_inputs(); clr_req = 1;
        tick();
        n_busy = 0;
        for (int j = 0; j < 10; j++) begin
            idle_inputs();
            dis_sel = 7;
            ra = {3'(j), 3'(j - 1)};
            if (j < 8) begin
                we0 = 1; wa0 = 0; wd0 = 16'hDEAD; rsv_en = 1; rsv_addr = 3;
                if (j == 2) clr_req = 1;
            end
            #3;
            if (clr_busy === 1'b1) n_busy++;
            if (j < 8) begin
                exp_q.push_back(model[j]);
                want = (j < 7) ? 16'h8888 : 16'h8888;
                vectors++; if (dis_data !== want) begin miscompares++; $display("FAIL clr_dis_old j=%0d got %h want %h", j, dis_data, want); end
                got = exp_q.pop_front();
                vectors++; if (rd1 !== got) begin miscompares++; $display("FAIL clr_pending j=%0d got %h want %h", j, rd1, got); end
                vectors++; if (rd_busy !== 2'b00) begin miscompares++; $display("FAIL clr_rd_busy j=%0d got %b want 00", j, rd_busy); end
            end
            if (j > 0 && j <= 8) begin
                vectors++; if (rd0 !== 16'h0) begin miscompares++; $display("FAIL clr_zeroed j=%0d got %h want 0", j, rd0); end
            end
            tick();
        end
        idle_inputs();
        vectors++; if (n_busy !== 8) begin miscompares++; $display("FAIL clr_cycles got %0d want 8", n_busy); end
        vectors++; if (busy !== 8'h00) begin miscompares++; $display("FAIL clr_busy_vec got %h want 00", busy); end
        for (int i = 0; i < 8; i++) begin
            dis_sel = 3'(i);
            #1;
            vectors++; if (dis_data !== 16'h0) begin miscompares++; $display("FAIL clr_final R%0d got %h want 0", i, dis_data); end
        end
        tick();
    endtask

    task automatic test_bypass_mode();
        idle_inputs(); we0 = 1; wa0 = 6; wd0 = 16'h00FF; ra = {3'd0, 3'd6};
        exp_q.push_back(BYP ? 16'h00FF : 16'h0000);
        #3;
        got = exp_q.pop_front();
        vectors++; if (rd0 !== got) begin miscompares++; $display("FAIL byp_same got %h want %h", rd0, got); end
        tick();
        we0 = 0;
        exp_q.push_back(16'h00FF);
        #3;
        got = exp_q.pop_front();
        vectors++; if (rd0 !== got) begin miscompares++; $display("FAIL byp_next got %h want %h", rd0, got); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_priority();
        test_scoreboard();
        test_rsv_wb();
        test_clear();
        test_bypass_mode();
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL queue_drain got %0d want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
